// File: rtl/mvm_ctrl_pkg.sv
// rtl/mvm_ctrl_pkg.sv - shared state encoding, default sizes and result type for the MVM job sequencer
package mvm_ctrl_pkg;

  localparam int K_DEFAULT = 8;
  localparam int B_DEFAULT = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PULSE_A,
    S_LOAD_A,
    S_PULSE_X,
    S_LOAD_X,
    S_WAIT_FIFO,
    S_START,
    S_WAIT_DONE,
    S_CAPTURE,
    S_ABORT
  } state_t;

  typedef logic signed [2*B_DEFAULT-1:0] res_t;

endpackage

// File: rtl/mvm_result_fifo.sv
// rtl/mvm_result_fifo.sv - DEPTH x W synchronous result FIFO, first word always visible on rd_data
module mvm_result_fifo
  import mvm_ctrl_pkg::*;
#(
  parameter int DEPTH = K_DEFAULT,
  parameter int W     = 2*B_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_fire, rd_fire;

  // A read in the same cycle frees the slot, so a write at full is still safe.
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_fire) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      if (wr_fire && !rd_fire)      count <= count + (AW+1)'(1);
      else if (rd_fire && !wr_fire) count <= count - (AW+1)'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);

endmodule

// File: rtl/mvm_seq_ctrl.sv
// rtl/mvm_seq_ctrl.sv - job sequencer driving the mvm_8_8_12_1 datapath and buffering its results
// Define MVM_CTRL_TIMEOUT_EN to abort a job after TIMEOUT cycles in WAIT_DONE without mvm_done.
module mvm_seq_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int K = K_DEFAULT,
  parameter int B = B_DEFAULT
`ifdef MVM_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           mvm_reset,
  output logic           mvm_loadMatrix,
  output logic           mvm_loadVector,
  output logic           mvm_start,
  output logic [B-1:0]   mvm_data_in,
  input  logic           mvm_done,
  input  logic [2*B-1:0] mvm_data_out,
  output logic           busy,
  output logic           err
);

  localparam logic [6:0] LAST_A = 7'(K*K - 1);
  localparam logic [6:0] LAST_X = 7'(K - 1);

  state_t     state, state_nxt;
  logic [6:0] cnt;
  logic       accept, fifo_wr, fifo_full, fifo_empty, tmo_hit;

  assign accept    = in_ready & in_valid;
  assign busy      = (state != S_IDLE);
  assign mvm_reset = reset | (state == S_ABORT);
  assign out_valid = ~fifo_empty;

`ifdef MVM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     tmo_cnt <= '0;
    else if (state == S_WAIT_DONE) tmo_cnt <= tmo_cnt + TW'(1);
    else                           tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    fifo_wr   = 1'b0;
    case (state)
      S_IDLE:    if (in_valid) state_nxt = S_PULSE_A;
      S_PULSE_A: state_nxt = S_LOAD_A;
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (!in_valid)           state_nxt = S_ABORT;
        else if (cnt == LAST_A)  state_nxt = S_PULSE_X;
      end
      S_PULSE_X: state_nxt = S_LOAD_X;
      S_LOAD_X: begin
        in_ready = 1'b1;
        if (!in_valid)           state_nxt = S_ABORT;
        else if (cnt == LAST_X)  state_nxt = fifo_empty ? S_START : S_WAIT_FIFO;
      end
      S_WAIT_FIFO: if (fifo_empty) state_nxt = S_START;
      S_START:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (mvm_done)     state_nxt = S_CAPTURE;
        else if (tmo_hit) state_nxt = S_ABORT;
      end
      S_CAPTURE: begin
        fifo_wr = ~fifo_full;
        if (cnt == LAST_X) state_nxt = S_IDLE;
      end
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Pulses and data are registered so the MVM sees each word the cycle after its load pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      mvm_loadMatrix <= 1'b0;
      mvm_loadVector <= 1'b0;
      mvm_start      <= 1'b0;
      mvm_data_in    <= '0;
      err            <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)               cnt <= '0;
      else if (accept || state == S_CAPTURE) cnt <= cnt + 7'd1;
      mvm_loadMatrix <= (state == S_PULSE_A);
      mvm_loadVector <= (state == S_PULSE_X);
      mvm_start      <= (state == S_START);
      mvm_data_in    <= accept ? in_data : '0;
      if (state == S_ABORT) err <= 1'b1;
      else if (accept)      err <= 1'b0;
    end
  end

  mvm_result_fifo #(
    .DEPTH(K),
    .W    (2*B)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .wr_en  (fifo_wr),
    .wr_data(mvm_data_out),
    .rd_en  (out_ready),
    .rd_data(out_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb/tb_mvm_seq_ctrl.sv - directed/random bench for mvm_seq_ctrl with an MVM model and result scoreboard
module tb_mvm_seq_ctrl;
  import mvm_ctrl_pkg::*;

  localparam int K  = 8;
  localparam int B  = 12;
  localparam int NW = K*K + K;

  logic           clk, reset;
  logic           in_valid, in_ready;
  logic [B-1:0]   in_data;
  logic           out_valid, out_ready;
  logic [2*B-1:0] out_data;
  logic           mvm_reset, mvm_loadMatrix, mvm_loadVector, mvm_start;
  logic [B-1:0]   mvm_data_in;
  logic           mvm_done;
  logic [2*B-1:0] mvm_data_out;
  logic           busy, err;

  int tests = 0;
  int fails = 0;

  int cyc = 0, lm_cnt = 0, lv_cnt = 0, st_cnt = 0, rst_cnt = 0;
  int lm_cyc = 0, st_cyc = 0, dn_cyc = 0, ov_cyc = 0, rst_cyc = 0;
  int rdy_mode = 1;
  bit hang = 0;

  logic signed [B-1:0] job [NW];
  res_t exp_q [$];

`ifdef MVM_CTRL_TIMEOUT_EN
  mvm_seq_ctrl #(.K(K), .B(B), .TIMEOUT(16)) dut (
`else
  mvm_seq_ctrl #(.K(K), .B(B)) dut (
`endif
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mvm_reset(mvm_reset), .mvm_loadMatrix(mvm_loadMatrix), .mvm_loadVector(mvm_loadVector),
    .mvm_start(mvm_start), .mvm_data_in(mvm_data_in), .mvm_done(mvm_done),
    .mvm_data_out(mvm_data_out), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // MVM datapath model plus pulse monitor; everything happens mid-cycle.
  initial begin
    logic signed [B-1:0] ma [K*K];
    logic signed [B-1:0] mx [K];
    res_t   my [K];
    int     amode, aidx, lat, oidx;
    bit     ov_prev;
    longint acc;
    amode = 0; aidx = 0; lat = 0; oidx = -1; ov_prev = 0;
    mvm_done = 1'b0;
    mvm_data_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (out_valid && !ov_prev) ov_cyc = cyc;
      ov_prev = out_valid;
      if (mvm_reset) begin
        if (!reset) begin rst_cnt++; rst_cyc = cyc; end
        amode = 0; lat = 0; oidx = -1;
        mvm_done = 1'b0;
        mvm_data_out = '0;
      end else begin
        mvm_done = 1'b0;
        if (oidx >= 0) begin
          mvm_data_out = my[oidx];
          oidx = (oidx == K-1) ? -1 : oidx + 1;
        end
        if (amode == 1) begin
          ma[aidx] = mvm_data_in; aidx++;
          if (aidx == K*K) amode = 0;
        end else if (amode == 2) begin
          mx[aidx] = mvm_data_in; aidx++;
          if (aidx == K) amode = 0;
        end
        if (mvm_loadMatrix) begin amode = 1; aidx = 0; lm_cnt++; lm_cyc = cyc; end
        if (mvm_loadVector) begin amode = 2; aidx = 0; lv_cnt++; end
        if (mvm_start) begin
          st_cnt++; st_cyc = cyc;
          for (int i = 0; i < K; i++) begin
            acc = 0;
            for (int j = 0; j < K; j++) acc += longint'(ma[i*K+j]) * longint'(mx[j]);
            my[i] = acc[2*B-1:0];
          end
          lat = hang ? 0 : int'($urandom_range(1, 4));
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin mvm_done = 1'b1; oidx = 0; dn_cyc = cyc; end
        end
      end
    end
  end

  // Result consumer and scoreboard.
  initial begin
    logic [2*B-1:0] e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready && !reset) begin
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < NW; i++) job[i] = 12'($urandom_range(0, 4095));
  endtask

  task automatic push_golden();
    longint acc;
    for (int i = 0; i < K; i++) begin
      acc = 0;
      for (int j = 0; j < K; j++) acc += longint'(job[i*K+j]) * longint'(job[K*K+j]);
      exp_q.push_back(acc[2*B-1:0]);
    end
  endtask

  task automatic send_job(input int gap_at);
    int idx, n;
    idx = 0; n = 0;
    in_data = job[0];
    in_valid = 1'b1;
    while (idx < NW && n < 1000) begin
      tick(); n++;
      if (in_ready) begin
        if (idx == gap_at) begin
          in_valid = 1'b0;
          idx = NW;
        end else begin
          @(posedge clk); #1;
          idx++;
          in_data = (idx < NW) ? job[idx] : '0;
        end
      end
    end
    in_valid = 1'b0;
    in_data = '0;
    chk("send_budget", n < 1000, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin tick(); n++; end
    chk("drain_budget", n < 2000, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_loadMatrix"}, mvm_loadMatrix, 0);
    chk({tag, "_loadVector"}, mvm_loadVector, 0);
    chk({tag, "_start"}, mvm_start, 0);
    chk({tag, "_mvm_data_in"}, mvm_data_in, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_mvm_reset"}, mvm_reset, 1);
  endtask

  initial begin
    int n, run, l0, v0, s0, r0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();
    chk("post_reset_mvm_reset", mvm_reset, 0);

    // Nominal: identity matrix, x = 1..8.
    rdy_mode = 1;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) job[i*K+j] = (i == j) ? 12'sd1 : 12'sd0;
    for (int j = 0; j < K; j++) job[K*K+j] = 12'(j + 1);
    for (int i = 0; i < K; i++) exp_q.push_back(res_t'(i + 1));
    l0 = lm_cnt; v0 = lv_cnt; s0 = st_cnt;
    send_job(-1);
    n = 0;
    while (!out_valid && n < 300) begin tick(); n++; end
    chk("nominal_out_seen", n < 300, 1);
    run = 0;
    while (out_valid && run < 20) begin run++; tick(); end
    chk("nominal_consecutive", run, K);
    chk("nominal_loadMatrix_pulses", lm_cnt - l0, 1);
    chk("nominal_loadVector_pulses", lv_cnt - v0, 1);
    chk("nominal_start_pulses", st_cnt - s0, 1);
    chk("load_to_start_cycles", st_cyc - lm_cyc, K*K + K + 2);
    chk("done_to_out_valid", ov_cyc - dn_cyc, 2);
    wait_drain();

    // Random jobs with random upstream idle gaps and random backpressure.
    rdy_mode = 2;
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(0, 5)) tick();
      fill_random();
      push_golden();
      send_job(-1);
      chk("random_err", err, 0);
    end
    rdy_mode = 1;
    wait_drain();
    chk("random_queue_empty", exp_q.size(), 0);

    // Gap abort at matrix word 20, then resend.
    fill_random();
    r0 = rst_cnt;
    send_job(20);
    repeat (3) tick();
    chk("gap_reset_pulses", rst_cnt - r0, 1);
    chk("gap_err", err, 1);
    chk("gap_idle", busy, 0);
    push_golden();
    send_job(-1);
    chk("resend_err_cleared", err, 0);
    wait_drain();
    chk("resend_queue_empty", exp_q.size(), 0);

    // Backpressure: job 2's START must wait for job 1's results to drain.
    rdy_mode = 0;
    fill_random(); push_golden(); send_job(-1);
    fill_random(); push_golden(); send_job(-1);
    s0 = st_cnt;
    repeat (30) tick();
    chk("bp_start_held", st_cnt, s0);
    chk("bp_busy", busy, 1);
    chk("bp_out_valid", out_valid, 1);
    rdy_mode = 1;
    wait_drain();
    chk("bp_start_after_drain", st_cnt, s0 + 1);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Reset three cycles after mvm_start while waiting for done.
    hang = 1;
    fill_random();
    s0 = st_cnt;
    send_job(-1);
    n = 0;
    while (st_cnt == s0 && n < 300) begin tick(); n++; end
    chk("rst_start_seen", n < 300, 1);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_zero_outputs("midrst");
    tick();
    reset = 1'b0;
    hang = 0;
    fill_random(); push_golden(); send_job(-1);
    wait_drain();
    chk("after_reset_queue_empty", exp_q.size(), 0);

`ifdef MVM_CTRL_TIMEOUT_EN
    hang = 1;
    fill_random();
    r0 = rst_cnt;
    send_job(-1);
    n = 0;
    while (rst_cnt == r0 && n < 300) begin tick(); n++; end
    chk("timeout_abort_seen", n < 300, 1);
    chk("timeout_cycles", rst_cyc - st_cyc, 16);
    tick();
    chk("timeout_err", err, 1);
    chk("timeout_no_results", out_valid, 0);
    hang = 0;
`endif

    wait_drain();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
